inst_encoder: RTL and testbench
===============================

# inst_encoder

Instruction encoder for the RISC-V core: accepts decoded instruction fields (format, opcode, registers, functs, 32-bit immediate), packs them into a 32-bit RV32I instruction word with the immediate scattered per format, range-checks the immediate, and emits the word with a word-aligned write address. It feeds the instruction-memory loader and the test-program injector. It is the inverse of the immediate generator.

## Interface
Parameters:
- ADDR_W, 12, width of the byte write-address counter.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input fields valid.
- in_ready  out  1  encoder can accept; transfer when in_valid && in_ready.
- in_fmt  in  3  format: R=0, I=1, S=2, B=3, U=4, J=5; 6,7 illegal.
- in_opcode  in  7  opcode, placed in inst[6:0] unchanged.
- in_rd, in_rs1, in_rs2  in  5 each  register indices.
- in_funct3  in  3; in_funct7  in  7.
- in_imm  in  32  immediate as the value the immediate generator would return.
- out_valid  out  1  encoded word valid.
- out_ready  in  1  consumer accepts; transfer when out_valid && out_ready.
- out_inst  out  32  encoded instruction.
- out_addr  out  ADDR_W  byte address of out_inst.
- out_err  out  1  immediate out of range, misaligned, or illegal format for this word.
- addr_load  in  1  load address counter.
- addr_in  in  ADDR_W  load value; bits [1:0] ignored (forced 0).
- err_sticky  out  1  OR of all out_err words transferred since reset/clear.
- err_clr  in  1  clears err_sticky.

## Operation
- Field placement: R: funct7|rs2|rs1|funct3|rd|op. I: imm[11:0]|rs1|funct3|rd|op. S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|op. B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|op. U: imm[31:12]|rd|op. J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op.
- Unused fields of a format are ignored (e.g. rs2 for I, rd for S/B).
- out_err set when: I/S imm not in [-2048, 2047]; B imm not in [-4096, 4094] or imm[0]=1; J imm not in [-2^20, 2^20-2] or imm[0]=1; U imm[11:0]≠0; fmt ∈ {6,7}. Errored words are still emitted with truncated immediate bits; illegal fmt emits 0x00000013 (nop) with out_err=1.
- Address counter: out_addr holds current counter; on each output transfer it increments by 4, wrapping from 2^ADDR_W-4 to 0.
- addr_load: counter := {addr_in[ADDR_W-1:2],2'b00}. Simultaneous with output transfer: the transferred word carries the old address; load wins over increment. Load also retargets a word already held but not yet transferred.
- err_sticky sets on transfer of a word with out_err=1; err_clr same cycle as such a transfer: set wins.

## Timing
- Reset values: in_ready=0 during rst then 1 the first cycle after, out_valid=0, out_inst=0, out_addr=0, out_err=0, err_sticky=0, skid buffer empty.
- Latency: 1 cycle from input transfer to out_valid (output register empty).
- Throughput: 1 word/cycle with out_ready held high.
- Output register plus 1-entry skid buffer; in_ready is a registered signal = skid empty. out_ready low with output full: next accepted word goes to skid, in_ready drops next cycle. Order strictly preserved.
- out_inst/out_err/out_valid stable while out_valid && !out_ready.
- Reset mid-operation: all held words discarded, counter to 0.

## Structure
- Format codes and opcode constants live in defines.v alongside the existing opcode and IR-field defines; no local literals.
- One combinational sub-module inst_pack (fields -> word + err); inst_encoder holds the handshake, skid buffer, address counter and sticky error.

## Test plan
- I: fmt=1, op=0x13, rd=1, rs1=0, f3=0, imm=5 -> out_inst=0x00500093, out_addr=0, out_err=0, one cycle after accept.
- S then U back to back: sw x2,8(x1) -> 0x0020A423 @0; lui x5,0x12345000 -> 0x123452B7 @4.
- J: jal x1,imm=-4 (0xFFFFFFFC) -> 0xFFDFF0EF; B with imm=3 -> out_err=1, err_sticky=1 after transfer; err_clr -> 0.
- Range: I imm=2048 -> out_err=1; imm=-2048 -> out_err=0; fmt=7 -> 0x00000013, out_err=1.
- Backpressure: out_ready=0 for 3 cycles while sending 3 words -> in_ready drops after second, no loss/duplication, addresses 0,4,8.
- Wrap/load: ADDR_W=4, counter at 12 -> next addr 0; addr_load=1, addr_in=7 during transfer -> transferred word @ old addr, next @ 4.

Source files
------------

// File: rtl/inst_encoder_pkg.sv
// Shared definitions for the RV32I instruction encoder: format codes, the
// canonical nop word and the signed-immediate range helper.
package inst_encoder_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    // True when imm[31:top] are all equal, i.e. imm fits a (top+1)-bit signed field.
    function automatic logic imm_fits(input logic [31:0] imm, input logic [4:0] top);
        logic [31:0] mask;
        mask = 32'hFFFF_FFFF << top;
        return ((imm & mask) == 32'h0000_0000) || ((imm & mask) == mask);
    endfunction

endpackage

// File: rtl/inst_pack.sv
// Combinational packer: scatters decoded fields and immediate into an RV32I
// word and flags out-of-range, misaligned or illegal-format immediates.
module inst_pack
    import inst_encoder_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic [31:0] inst,
    output logic        err
);

    // field placement and range check per instruction format
    always_comb begin
        inst = INST_NOP;
        err  = 1'b1;
        case (fmt_e'(fmt))
            FMT_R: begin
                inst = {funct7, rs2, rs1, funct3, rd, opcode};
                err  = 1'b0;
            end
            FMT_I: begin
                inst = {imm[11:0], rs1, funct3, rd, opcode};
                err  = !imm_fits(imm, 5'd11);
            end
            FMT_S: begin
                inst = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                err  = !imm_fits(imm, 5'd11);
            end
            FMT_B: begin
                inst = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                err  = !imm_fits(imm, 5'd12) || imm[0];
            end
            FMT_U: begin
                inst = {imm[31:12], rd, opcode};
                err  = (imm[11:0] != 12'h000);
            end
            FMT_J: begin
                inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                err  = !imm_fits(imm, 5'd20) || imm[0];
            end
            default: begin
                inst = INST_NOP;
                err  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/inst_encoder.sv
// Instruction encoder top: valid/ready handshake with output register plus a
// one-entry skid buffer, word-aligned write-address counter and sticky error.
module inst_encoder
    import inst_encoder_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_fmt,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_inst,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err,
    input  logic              addr_load,
    input  logic [ADDR_W-1:0] addr_in,
    output logic              err_sticky,
    input  logic              err_clr
);

    localparam logic [ADDR_W-1:0] ADDR_STEP  = {{(ADDR_W-3){1'b0}}, 3'd4};
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~{{(ADDR_W-2){1'b0}}, 2'b11};

    logic [31:0]       pack_inst_s;
    logic              pack_err_s;
    logic              accept_s;
    logic              out_xfer_s;
    logic              out_free_s;
    logic              skid_load_s;
    logic              skid_next_s;
    logic              out_valid_r;
    logic [31:0]       out_inst_r;
    logic              out_err_r;
    logic              skid_valid_r;
    logic [31:0]       skid_inst_r;
    logic              skid_err_r;
    logic              in_ready_r;
    logic              err_sticky_r;
    logic [ADDR_W-1:0] addr_r;

    inst_pack u_pack (
        .fmt    (in_fmt),
        .opcode (in_opcode),
        .rd     (in_rd),
        .rs1    (in_rs1),
        .rs2    (in_rs2),
        .funct3 (in_funct3),
        .funct7 (in_funct7),
        .imm    (in_imm),
        .inst   (pack_inst_s),
        .err    (pack_err_s)
    );

    assign accept_s    = in_valid && in_ready_r;
    assign out_xfer_s  = out_valid_r && out_ready;
    assign out_free_s  = !out_valid_r || out_xfer_s;
    // the skid can only fill while empty, since in_ready mirrors its emptiness
    assign skid_load_s = accept_s && !out_free_s;
    assign skid_next_s = skid_load_s || (skid_valid_r && !out_free_s);

    // output register, skid buffer and registered in_ready
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r  <= 1'b0;
            out_inst_r   <= 32'h0000_0000;
            out_err_r    <= 1'b0;
            skid_valid_r <= 1'b0;
            skid_inst_r  <= 32'h0000_0000;
            skid_err_r   <= 1'b0;
            in_ready_r   <= 1'b0;
        end else begin
            if (out_free_s) begin
                if (skid_valid_r) begin
                    out_valid_r <= 1'b1;
                    out_inst_r  <= skid_inst_r;
                    out_err_r   <= skid_err_r;
                end else if (accept_s) begin
                    out_valid_r <= 1'b1;
                    out_inst_r  <= pack_inst_s;
                    out_err_r   <= pack_err_s;
                end else begin
                    out_valid_r <= 1'b0;
                end
            end
            if (skid_load_s) begin
                skid_inst_r <= pack_inst_s;
                skid_err_r  <= pack_err_s;
            end
            skid_valid_r <= skid_next_s;
            in_ready_r   <= !skid_next_s;
        end
    end

    // write-address counter; a load overrides the post-transfer increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_r <= {ADDR_W{1'b0}};
        end else if (addr_load) begin
            addr_r <= addr_in & ALIGN_MASK;
        end else if (out_xfer_s) begin
            addr_r <= addr_r + ADDR_STEP;
        end
    end

    // sticky error; a transferring errored word beats a same-cycle clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_sticky_r <= 1'b0;
        end else if (out_xfer_s && out_err_r) begin
            err_sticky_r <= 1'b1;
        end else if (err_clr) begin
            err_sticky_r <= 1'b0;
        end
    end

    assign in_ready   = in_ready_r;
    assign out_valid  = out_valid_r;
    assign out_inst   = out_inst_r;
    assign out_err    = out_err_r;
    assign out_addr   = addr_r;
    assign err_sticky = err_sticky_r;

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: vector table through a scoreboard, a
// spec-level address/sticky model, plus hand sequences for multi-cycle cases.
module tb_inst_encoder;

    localparam int ADDR_W = 12;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_fmt;
    logic [6:0]        in_opcode;
    logic [4:0]        in_rd, in_rs1, in_rs2;
    logic [2:0]        in_funct3;
    logic [6:0]        in_funct7;
    logic [31:0]       in_imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_inst;
    logic [ADDR_W-1:0] out_addr;
    logic              out_err;
    logic              addr_load;
    logic [ADDR_W-1:0] addr_in;
    logic              err_sticky;
    logic              err_clr;

    inst_encoder #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
        .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
        .out_addr(out_addr), .out_err(out_err),
        .addr_load(addr_load), .addr_in(addr_in),
        .err_sticky(err_sticky), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] exp_inst;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] inst;
        logic        err;
    } exp_t;

    exp_t              scb[$];
    vec_t              vecs[20];
    int                passed = 0;
    int                total  = 0;
    logic [ADDR_W-1:0] m_addr;
    logic              m_sticky;
    logic              hold_prev;
    logic [31:0]       inst_prev;
    logic              err_prev;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic [2:0] fmt, input logic [6:0] op,
                                input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm,
                                input logic [31:0] exp_inst, input logic exp_err);
        vec_t v;
        v.fmt = fmt; v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
        v.f3 = f3; v.f7 = f7; v.imm = imm; v.exp_inst = exp_inst; v.exp_err = exp_err;
        return v;
    endfunction

    // Monitor: checks every output transfer against the scoreboard and the address/sticky model.
    always @(negedge clk) begin
        if (rst) begin
            scb.delete();
            m_addr    = '0;
            m_sticky  = 1'b0;
            hold_prev = 1'b0;
        end else begin
            logic xfer_err;
            xfer_err = 1'b0;
            check("out_addr", 32'(out_addr), 32'(m_addr));
            check("err_sticky", {31'd0, err_sticky}, {31'd0, m_sticky});
            if (hold_prev) begin
                check("hold_valid", {31'd0, out_valid}, 32'd1);
                check("hold_inst", out_inst, inst_prev);
                check("hold_err", {31'd0, out_err}, {31'd0, err_prev});
            end
            if (out_valid && out_ready) begin
                if (scb.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_word: got inst 0x%08h expected no word", out_inst);
                end else begin
                    exp_t e;
                    e = scb.pop_front();
                    check("out_inst", out_inst, e.inst);
                    check("out_err", {31'd0, out_err}, {31'd0, e.err});
                    xfer_err = e.err;
                end
            end
            if (out_valid && out_ready && xfer_err) m_sticky = 1'b1;
            else if (err_clr) m_sticky = 1'b0;
            if (addr_load) m_addr = addr_in & 12'hFFC;
            else if (out_valid && out_ready) m_addr = m_addr + 12'd4;
            hold_prev = out_valid && !out_ready;
            inst_prev = out_inst;
            err_prev  = out_err;
        end
    end

    task automatic send(input vec_t v);
        int n;
        n = 0;
        in_fmt = v.fmt; in_opcode = v.op; in_rd = v.rd; in_rs1 = v.rs1; in_rs2 = v.rs2;
        in_funct3 = v.f3; in_funct7 = v.f7; in_imm = v.imm;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                scb.push_back('{v.exp_inst, v.exp_err});
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
            n++;
            if (n > 50) begin
                total++;
                $display("FAIL send_timeout: in_ready still 0 after %0d cycles, expected 1", n);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (scb.size() != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (scb.size() != 0) begin
            total++;
            $display("FAIL drain_timeout: pending %0d words, expected 0", scb.size());
        end
    endtask

    task automatic load_addr(input logic [ADDR_W-1:0] a);
        addr_load = 1'b1;
        addr_in   = a;
        @(posedge clk); #1;
        addr_load = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: bench still running, expected finish");
        $fatal(1);
    end

    initial begin
        vecs[0]  = mk(3'd1, 7'h13, 5'd1, 5'd0, 5'd31, 3'd0, 7'h00, 32'd5,        32'h0050_0093, 1'b0);
        vecs[1]  = mk(3'd2, 7'h23, 5'd9, 5'd1, 5'd2,  3'd2, 7'h00, 32'd8,        32'h0020_A423, 1'b0);
        vecs[2]  = mk(3'd4, 7'h37, 5'd5, 5'd0, 5'd0,  3'd0, 7'h00, 32'h12345000, 32'h1234_52B7, 1'b0);
        vecs[3]  = mk(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0,  3'd0, 7'h00, 32'hFFFFFFFC, 32'hFFDF_F0EF, 1'b0);
        vecs[4]  = mk(3'd3, 7'h63, 5'd0, 5'd1, 5'd2,  3'd0, 7'h00, 32'd3,        32'h0020_8163, 1'b1);
        vecs[5]  = mk(3'd1, 7'h13, 5'd1, 5'd0, 5'd0,  3'd0, 7'h00, 32'd2048,     32'h8000_0093, 1'b1);
        vecs[6]  = mk(3'd1, 7'h13, 5'd1, 5'd0, 5'd0,  3'd0, 7'h00, 32'hFFFFF800, 32'h8000_0093, 1'b0);
        vecs[7]  = mk(3'd7, 7'h33, 5'd3, 5'd1, 5'd2,  3'd0, 7'h00, 32'd0,        32'h0000_0013, 1'b1);
        vecs[8]  = mk(3'd0, 7'h33, 5'd3, 5'd1, 5'd2,  3'd0, 7'h00, 32'hDEADBEEF, 32'h0020_81B3, 1'b0);
        vecs[9]  = mk(3'd0, 7'h33, 5'd3, 5'd1, 5'd2,  3'd0, 7'h20, 32'd0,        32'h4020_81B3, 1'b0);
        vecs[10] = mk(3'd1, 7'h13, 5'd1, 5'd0, 5'd0,  3'd0, 7'h00, 32'd2047,     32'h7FF0_0093, 1'b0);
        vecs[11] = mk(3'd3, 7'h63, 5'd0, 5'd1, 5'd2,  3'd0, 7'h00, 32'hFFFFF000, 32'h8020_8063, 1'b0);
        vecs[12] = mk(3'd3, 7'h63, 5'd0, 5'd1, 5'd2,  3'd0, 7'h00, 32'd4094,     32'h7E20_8FE3, 1'b0);
        vecs[13] = mk(3'd3, 7'h63, 5'd0, 5'd1, 5'd2,  3'd0, 7'h00, 32'd4096,     32'h8020_8063, 1'b1);
        vecs[14] = mk(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0,  3'd0, 7'h00, 32'h000FFFFE, 32'h7FFF_F0EF, 1'b0);
        vecs[15] = mk(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0,  3'd0, 7'h00, 32'h00100000, 32'h8000_00EF, 1'b1);
        vecs[16] = mk(3'd4, 7'h37, 5'd5, 5'd0, 5'd0,  3'd0, 7'h00, 32'h12345001, 32'h1234_52B7, 1'b1);
        vecs[17] = mk(3'd2, 7'h23, 5'd0, 5'd1, 5'd2,  3'd2, 7'h00, 32'hFFFFFFFF, 32'hFE20_AFA3, 1'b0);
        vecs[18] = mk(3'd2, 7'h23, 5'd0, 5'd1, 5'd2,  3'd2, 7'h00, 32'hFFFFF7FF, 32'h7E20_AFA3, 1'b1);
        vecs[19] = mk(3'd6, 7'h13, 5'd1, 5'd1, 5'd1,  3'd0, 7'h00, 32'd0,        32'h0000_0013, 1'b1);

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; addr_load = 1'b0; addr_in = '0; err_clr = 1'b0;
        in_fmt = '0; in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        in_funct3 = '0; in_funct7 = '0; in_imm = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_inst", out_inst, 32'h0000_0000);
        check("rst_out_addr", 32'(out_addr), 32'd0);
        check("rst_out_err", {31'd0, out_err}, 32'd0);
        check("rst_err_sticky", {31'd0, err_sticky}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // one-cycle latency
        send(vecs[0]);
        check("latency_valid", {31'd0, out_valid}, 32'd1);
        check("latency_inst", out_inst, 32'h0050_0093);

        for (int i = 1; i < 20; i++) send(vecs[i]);
        drain();
        @(posedge clk); #1;
        check("sticky_set", {31'd0, err_sticky}, 32'd1);
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        check("sticky_clr", {31'd0, err_sticky}, 32'd0);

        // backpressure: second word fills the skid and drops in_ready
        load_addr(12'd0);
        out_ready = 1'b0;
        send(vecs[0]);
        send(vecs[1]);
        check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        fork
            send(vecs[2]);
            begin
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        @(posedge clk); #1;
        check("bp_final_addr", 32'(out_addr), 32'd12);

        // clear coinciding with an errored transfer: set wins
        out_ready = 1'b0;
        send(vecs[4]);
        err_clr = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        check("sticky_set_wins", {31'd0, err_sticky}, 32'd1);
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        check("sticky_clr2", {31'd0, err_sticky}, 32'd0);

        // wrap from the top word to zero; low bits of addr_in ignored
        load_addr(12'hFFE);
        check("load_align", 32'(out_addr), 32'h0000_0FFC);
        send(vecs[8]);
        send(vecs[9]);
        drain();
        @(posedge clk); #1;
        check("wrap_addr", 32'(out_addr), 32'd4);

        // load during a transfer: word keeps old address, load beats increment
        load_addr(12'h020);
        out_ready = 1'b0;
        send(vecs[10]);
        out_ready = 1'b1; addr_load = 1'b1; addr_in = 12'd7;
        @(posedge clk); #1;
        addr_load = 1'b0;
        check("load_xfer_addr", 32'(out_addr), 32'd4);
        send(vecs[2]);
        drain();

        // load retargets a held word
        out_ready = 1'b0;
        send(vecs[3]);
        load_addr(12'h100);
        check("retarget_addr", 32'(out_addr), 32'h0000_0100);
        out_ready = 1'b1;
        drain();

        // reset mid-operation discards held words
        out_ready = 1'b0;
        send(vecs[0]);
        send(vecs[1]);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        check("midrst_addr", 32'(out_addr), 32'd0);
        rst = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("midrst_no_word", {31'd0, out_valid}, 32'd0);
        check("midrst_ready", {31'd0, in_ready}, 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
